hex_display_bcd: RTL and testbench

- Downstream consumer of the CPU's 32-bit gpio_out (CSR io2); drives the eight seven-segment displays HEX0..HEX7.
- Decimal mode: an iterative double-dabble converter (one shift per clock) produces unsigned decimal digits.
- Hex mode: nibbles are shown directly.
- Re-converts automatically whenever the input value or the mode changes.

---
 rtl/hex_display_bcd_pkg.sv | 26 ++
 rtl/hex_display_bcd_if.sv | 20 ++
 rtl/hex_display_bcd_seven_seg_enc.sv | 9 +
 rtl/hex_display_bcd.sv | 140 ++++++++++++++
 tb/tb_hex_display_bcd.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_display_bcd_pkg.sv
// Shared types and constants for the eight-digit seven-segment display driver.
package display_pkg;

   localparam int NUM_HEX_DEF    = 8;
   localparam int BCD_DIGITS_DEF = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'h40;

   // Active-low {g,f,e,d,c,b,a} patterns, index 15 (F) first down to index 0.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
      return (digit >= 4'd5) ? digit + 4'd3 : digit;
   endfunction

endpackage

// File: rtl/hex_display_bcd_if.sv
// Value/mode input and segment/status output bundle between the CPU side and the display driver.
interface hex_display_bcd_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] value;
   logic              hex_mode;
   logic [6:0]        hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic              busy;
   logic              overflow;

   modport master (
      output value, hex_mode,
      input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, overflow
   );

   modport slave (
      input  value, hex_mode,
      output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, overflow
   );
endinterface

// File: rtl/hex_display_bcd_seven_seg_enc.sv
// Combinational nibble to active-low seven-segment pattern.
module seven_seg_enc
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/hex_display_bcd.sv
// Drives eight seven-segment displays from a 32-bit value, in hex or iterative double-dabble decimal.
// Optional build macro HEX_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module hex_display_bcd
   import display_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int BCD_DIGITS = BCD_DIGITS_DEF,
   parameter int NUM_HEX    = NUM_HEX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   hex_display_bcd_if.slave  bus
);

   localparam int                BCD_W    = 4 * BCD_DIGITS;
   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

   state_t                       state_q, state_d;
   logic [DATA_W-1:0]            value_q;
   logic                         mode_q;
   logic [DATA_W-1:0]            snap_val_q, snap_val_d;
   logic                         snap_mode_q, snap_mode_d;
   logic [BCD_W-1:0]             bcd_q, bcd_d, bcd_adj;
   logic [DATA_W-1:0]            shift_q, shift_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [NUM_HEX-1:0][3:0]      digit_q, digit_d;
   logic [NUM_HEX-1:0]           blank_q, blank_d;
   logic                         overflow_q, overflow_d;
   logic [NUM_HEX-1:0][6:0]      enc_seg, hex_seg;

   // Add-3 correction on every BCD digit in parallel before each shift.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         bcd_adj[4*i +: 4] = bcd_add3(bcd_q[4*i +: 4]);
      end
   end

   // NOTE: every variable is given its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d     = state_q;
      snap_val_d  = snap_val_q;
      snap_mode_d = snap_mode_q;
      bcd_d       = bcd_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      digit_d     = digit_q;
      blank_d     = blank_q;
      overflow_d  = overflow_q;

      unique case (state_q)
         IDLE: begin
            if ({value_q, mode_q} != {snap_val_q, snap_mode_q}) begin
               snap_val_d  = value_q;
               snap_mode_d = mode_q;
               if (mode_q) begin
                  state_d = DONE;
               end else begin
                  bcd_d   = '0;
                  shift_d = value_q;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            for (int i = 0; i < NUM_HEX; i++) begin
               digit_d[i] = snap_mode_q ? snap_val_q[4*i +: 4] : bcd_q[4*i +: 4];
            end
            overflow_d = snap_mode_q ? 1'b0 : |bcd_q[BCD_W-1:4*NUM_HEX];
`ifdef HEX_LEADING_ZERO_BLANK_EN
            // Blank from the top down until the first nonzero digit; hex0 always shows.
            blank_d = '0;
            for (int i = NUM_HEX - 1; i >= 1; i--) begin
               blank_d[i] = (digit_d[i] == 4'd0) && ((i == NUM_HEX - 1) || blank_d[i+1]);
            end
`else
            blank_d = '0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         value_q     <= '0;
         mode_q      <= 1'b0;
         snap_val_q  <= '0;
         snap_mode_q <= 1'b0;
         bcd_q       <= '0;
         shift_q     <= '0;
         cnt_q       <= '0;
         digit_q     <= '0;
         blank_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         value_q     <= bus.value;
         mode_q      <= bus.hex_mode;
         snap_val_q  <= snap_val_d;
         snap_mode_q <= snap_mode_d;
         bcd_q       <= bcd_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         digit_q     <= digit_d;
         blank_q     <= blank_d;
         overflow_q  <= overflow_d;
      end
   end

   for (genvar g = 0; g < NUM_HEX; g++) begin : g_enc
      seven_seg_enc u_enc (
         .nibble (digit_q[g]),
         .seg    (enc_seg[g])
      );
      assign hex_seg[g] = blank_q[g] ? SEG_BLANK : enc_seg[g];
   end

   assign bus.hex0     = hex_seg[0];
   assign bus.hex1     = hex_seg[1];
   assign bus.hex2     = hex_seg[2];
   assign bus.hex3     = hex_seg[3];
   assign bus.hex4     = hex_seg[4];
   assign bus.hex5     = hex_seg[5];
   assign bus.hex6     = hex_seg[6];
   assign bus.hex7     = hex_seg[7];
   assign bus.busy     = (state_q != IDLE);
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_hex_display_bcd.sv
// Randomized self-checking bench for hex_display_bcd against an arithmetic display model.
module tb_hex_display_bcd;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [55:0] cur_disp;
   logic        cur_ovf;
   logic [55:0] dut_disp;

   logic [6:0] seg_ref [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   hex_display_bcd_if #(.DATA_W(32)) bus ();

   hex_display_bcd dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign dut_disp = {bus.hex7, bus.hex6, bus.hex5, bus.hex4,
                      bus.hex3, bus.hex2, bus.hex1, bus.hex0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: decimal digits by repeated division, hex digits by nibble extraction.
   task automatic model(input logic [31:0] v, input logic m,
                        output logic [55:0] d, output logic o);
      longint unsigned rem;
      int              dig [8];
      rem = 64'(v);
      for (int i = 0; i < 8; i++) begin
         if (m) begin
            dig[i] = int'((v >> (4 * i)) & 32'hF);
         end else begin
            dig[i] = int'(rem % 10);
            rem    = rem / 10;
         end
      end
      o = !m && (v > 32'd99999999);
      d = '0;
      for (int i = 0; i < 8; i++) d[7*i +: 7] = seg_ref[dig[i]];
`ifdef HEX_LEADING_ZERO_BLANK_EN
      for (int i = 7; i >= 1; i--) begin
         if (dig[i] != 0) break;
         d[7*i +: 7] = 7'h7F;
      end
`endif
   endtask

   // Apply a new input and check hold/busy every cycle until the expected latch edge.
   task automatic run_conv(input logic [31:0] v, input logic m, input string name);
      logic [55:0] exp_d;
      logic        exp_o;
      int          lat;
      model(v, m, exp_d, exp_o);
      lat = m ? 2 : 34;
      bus.value    = v;
      bus.hex_mode = m;
      for (int j = 1; j <= lat; j++) begin
         tick();
         total++;
         if (dut_disp !== cur_disp || bus.overflow !== cur_ovf) begin
            bad++;
            $display("FAIL %s hold cycle %0d: disp=%h ovf=%b expected disp=%h ovf=%b",
                     name, j, dut_disp, bus.overflow, cur_disp, cur_ovf);
         end
         total++;
         if (bus.busy !== (j >= 2)) begin
            bad++;
            $display("FAIL %s busy cycle %0d: got %b expected %b", name, j, bus.busy, (j >= 2));
         end
      end
      tick();
      total++;
      if (dut_disp !== exp_d || bus.overflow !== exp_o || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s result: disp=%h ovf=%b busy=%b expected disp=%h ovf=%b busy=0",
                  name, dut_disp, bus.overflow, bus.busy, exp_d, exp_o);
      end
      cur_disp = exp_d;
      cur_ovf  = exp_o;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.value    = '0;
      bus.hex_mode = 1'b0;
      repeat (3) tick();
      total++;
      if (dut_disp !== {8{7'h40}} || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: disp=%h busy=%b ovf=%b expected disp=%h busy=0 ovf=0",
                  dut_disp, bus.busy, bus.overflow, {8{7'h40}});
      end
      rst = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick();
         total++;
         if (bus.busy !== 1'b0 || dut_disp !== {8{7'h40}}) begin
            bad++;
            $display("FAIL reset_idle cycle %0d: busy=%b disp=%h expected busy=0 disp=%h",
                     j, bus.busy, dut_disp, {8{7'h40}});
         end
      end
      cur_disp = {8{7'h40}};
      cur_ovf  = 1'b0;
   endtask

   task automatic test_decimal();
      run_conv(32'h00BC614E, 1'b0, "dec_12345678");
   endtask

   task automatic test_hex();
      run_conv(32'hDEADBEEF, 1'b1, "hex_deadbeef");
   endtask

   task automatic test_overflow();
      run_conv(32'hFFFFFFFF, 1'b0, "dec_overflow");
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic        m;
      logic [31:0] last_v = 32'hFFFFFFFF;
      logic        last_m = 1'b0;
      for (int n = 0; n < 8; n++) begin
         v = $urandom;
         if (n % 3 == 0) v = v % 1000;
         m = 1'($urandom_range(0, 1));
         if (v == last_v && m == last_m) v = v ^ 32'h1;
         run_conv(v, m, $sformatf("random_%0d", n));
         last_v = v;
         last_m = m;
      end
   endtask

   task automatic test_back_to_back();
      logic [55:0] ea, eb;
      logic        oa, ob;
      model(32'd12345678, 1'b0, ea, oa);
      model(32'd87654321, 1'b0, eb, ob);
      bus.value    = 32'd12345678;
      bus.hex_mode = 1'b0;
      for (int j = 1; j <= 34; j++) begin
         tick();
         if (j == 11) bus.value = 32'd87654321;
         total++;
         if (dut_disp !== cur_disp) begin
            bad++;
            $display("FAIL b2b_hold_first cycle %0d: disp=%h expected %h", j, dut_disp, cur_disp);
         end
      end
      tick();
      total++;
      if (dut_disp !== ea || bus.overflow !== oa) begin
         bad++;
         $display("FAIL b2b_first: disp=%h ovf=%b expected disp=%h ovf=%b",
                  dut_disp, bus.overflow, ea, oa);
      end
      for (int k = 1; k <= 33; k++) begin
         tick();
         total++;
         if (dut_disp !== ea) begin
            bad++;
            $display("FAIL b2b_hold_second cycle %0d: disp=%h expected %h", k, dut_disp, ea);
         end
      end
      tick();
      total++;
      if (dut_disp !== eb || bus.overflow !== ob || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_second: disp=%h ovf=%b busy=%b expected disp=%h ovf=%b busy=0",
                  dut_disp, bus.overflow, bus.busy, eb, ob);
      end
      cur_disp = eb;
      cur_ovf  = ob;
   endtask

   task automatic test_reset_mid();
      bus.value    = 32'd999;
      bus.hex_mode = 1'b0;
      repeat (12) tick();
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_busy: got %b expected 1", bus.busy);
      end
      rst = 1'b1;
      tick();
      total++;
      if (dut_disp !== {8{7'h40}} || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_state: disp=%h busy=%b ovf=%b expected disp=%h busy=0 ovf=0",
                  dut_disp, bus.busy, bus.overflow, {8{7'h40}});
      end
      rst      = 1'b0;
      cur_disp = {8{7'h40}};
      cur_ovf  = 1'b0;
      run_conv(32'd999, 1'b0, "reset_mid_restart");
   endtask

   initial begin
      cur_disp = '0;
      cur_ovf  = 1'b0;
      test_reset();
      test_decimal();
      test_hex();
      test_overflow();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
